// File: rtl/spi_master.sv
// Mode-0, MSB-first SPI controller: one full-duplex WIDTH-bit exchange per start.
// Optional macro SPI_MASTER_CS_GUARD_EN adds a GUARD state holding ce0 high for H cycles.
module spi_master #(
   parameter int CLK_DIV = 4,
   parameter int WIDTH   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             mosi,
   output logic             ce0,
   input  logic             miso
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

`ifdef SPI_MASTER_CS_GUARD_EN
   typedef enum logic [2:0] {S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL, S_GUARD} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL} state_t;
`endif

   state_t             state, state_nxt;
   logic [DIV_W-1:0]   div, div_nxt;
   logic [BIT_W-1:0]   bitcnt, bitcnt_nxt;
   logic [WIDTH-1:0]   shreg, shreg_nxt;
   logic [WIDTH-1:0]   rx_nxt;
   logic               busy_nxt, done_nxt, sclk_nxt, mosi_nxt, ce0_nxt;
   logic               expire;

   assign expire = (div == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         div     <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         rx_data <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         ce0     <= 1'b1;
      end else begin
         state   <= state_nxt;
         div     <= div_nxt;
         bitcnt  <= bitcnt_nxt;
         shreg   <= shreg_nxt;
         rx_data <= rx_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         sclk    <= sclk_nxt;
         mosi    <= mosi_nxt;
         ce0     <= ce0_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      div_nxt    = '0;
      bitcnt_nxt = bitcnt;
      shreg_nxt  = shreg;
      rx_nxt     = rx_data;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      sclk_nxt   = sclk;
      mosi_nxt   = mosi;
      ce0_nxt    = ce0;

      // Every state change outside IDLE happens on expire, so the divider wraps exactly then.
      if (state != S_IDLE && !expire)
         div_nxt = div + DIV_W'(1);

      case (state)
         S_IDLE: begin
            if (start) begin
               shreg_nxt  = tx_data;
               ce0_nxt    = 1'b0;
               mosi_nxt   = tx_data[WIDTH-1];
               busy_nxt   = 1'b1;
               bitcnt_nxt = '0;
               state_nxt  = S_LEAD;
            end
         end
         S_LEAD, S_LOW: begin
            if (expire) begin
               sclk_nxt  = 1'b1;
               shreg_nxt = {shreg[WIDTH-2:0], miso};
               state_nxt = S_HIGH;
            end
         end
         S_HIGH: begin
            if (expire) begin
               sclk_nxt = 1'b0;
               if (bitcnt == BIT_LAST) begin
                  state_nxt = S_TRAIL;
               end else begin
                  // MSB of the shifted register is the next transmit bit.
                  bitcnt_nxt = bitcnt + BIT_W'(1);
                  mosi_nxt   = shreg[WIDTH-1];
                  state_nxt  = S_LOW;
               end
            end
         end
         S_TRAIL: begin
            if (expire) begin
               ce0_nxt  = 1'b1;
               rx_nxt   = shreg;
               done_nxt = 1'b1;
               mosi_nxt = 1'b0;
`ifdef SPI_MASTER_CS_GUARD_EN
               state_nxt = S_GUARD;
`else
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
`endif
            end
         end
`ifdef SPI_MASTER_CS_GUARD_EN
         S_GUARD: begin
            if (expire) begin
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: random and directed frames against a frame-level model,
// plus a CLK_DIV=2 instance for the minimum-divider case.
module tb_spi_master;

   localparam int H     = 4;
   localparam int W     = 8;
   localparam int DONE_AT = (2 * W + 1) * H;
`ifdef SPI_MASTER_CS_GUARD_EN
   localparam int NEXT_ACC     = (2 * W + 2) * H + 1;
   localparam int GAP          = H + 1;
   localparam int BUSY_AT_DONE = 1;
`else
   localparam int NEXT_ACC     = DONE_AT + 1;
   localparam int GAP          = 1;
   localparam int BUSY_AT_DONE = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [7:0] rx_data;
   logic       busy, done, sclk, mosi, ce0;
   logic       miso = 1'b0;

   spi_master #(.CLK_DIV(H), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
      .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .ce0(ce0), .miso(miso)
   );

   logic       start2 = 1'b0;
   logic [7:0] tx2 = 8'h00;
   logic [7:0] rx2;
   logic       busy2, done2, sclk2, mosi2, ce0_2;
   logic       miso2 = 1'b0;

   spi_master #(.CLK_DIV(2), .WIDTH(W)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .tx_data(tx2), .rx_data(rx2),
      .busy(busy2), .done(done2), .sclk(sclk2), .mosi(mosi2), .ce0(ce0_2), .miso(miso2)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
   } frame_t;

   frame_t     exp_q[$];
   logic [7:0] pq[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor + peripheral model: the peripheral shifts its byte out MSB first,
   // presenting each new bit after an sclk fall.
   logic       prev_ce0 = 1'b1, prev_sclk = 1'b0;
   int         t0 = 0, rise_cyc = 0, last_gap = -1, nbits = 0, hi_len = 0, hi_bad = 0;
   int         done_count = 0, pidx = 0;
   bit         have_rise = 0;
   logic [7:0] mosi_cap = 8'h00, pbyte = 8'h00;
   frame_t     f_mon;

   always @(negedge clk) begin
      if (rst) begin
         nbits = 0; hi_bad = 0; hi_len = 0; have_rise = 0; miso = 1'b0; pidx = 0;
      end else begin
         if (prev_ce0 && !ce0) begin
            t0 = cyc; nbits = 0; hi_bad = 0; mosi_cap = 8'h00;
            if (have_rise) last_gap = cyc - rise_cyc;
            pbyte = (pq.size() != 0) ? pq.pop_front() : 8'h00;
            pidx = 7;
            miso = pbyte[7];
         end
         if (!prev_sclk && sclk) begin
            mosi_cap = {mosi_cap[6:0], mosi};
            nbits++;
            hi_len = 1;
         end else if (sclk) begin
            hi_len++;
         end
         if (prev_sclk && !sclk) begin
            if (hi_len != H) hi_bad++;
            if (!ce0 && pidx > 0) begin
               pidx--;
               miso = pbyte[pidx];
            end
         end
         if (!prev_ce0 && ce0) begin
            rise_cyc = cyc;
            have_rise = 1;
         end
         if (done) begin
            done_count++;
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               f_mon = exp_q.pop_front();
               check("rx_data", rx_data, f_mon.rx);
               check("mosi_bits", mosi_cap, f_mon.tx);
               check("sclk_pulses", nbits, W);
               check("sclk_high_bad", hi_bad, 0);
               check("done_cycle", cyc - t0, DONE_AT);
               check("ce0_at_done", ce0, 1);
               check("busy_at_done", busy, BUSY_AT_DONE);
            end
         end
      end
      prev_ce0  = ce0;
      prev_sclk = sclk;
   end

   task automatic pulse_start(input logic [7:0] tx, input logic [7:0] mb, input bit expect_frame);
      @(negedge clk);
      tx_data = tx;
      start = 1'b1;
      if (expect_frame) begin
         exp_q.push_back('{tx: tx, rx: mb});
         pq.push_back(mb);
      end
      @(negedge clk);
      start = 1'b0;
      tx_data = 8'($urandom);
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int n = 0;
      while (done_count < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, done_count >= target, 1);
      repeat (2 * H) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, acc, lowcnt, dcyc;
      bit seen;

      @(negedge clk);
      @(negedge clk);
      check("rst_ce0", ce0, 1);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rx", rx_data, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed full-duplex byte.
      base = done_count;
      pulse_start(8'hA5, 8'h3C, 1);
      wait_done(base + 1, 200, "timeout_a5");

      // Random frames.
      for (int i = 0; i < 6; i++) begin
         base = done_count;
         pulse_start(8'($urandom), 8'($urandom), 1);
         wait_done(base + 1, 200, "timeout_rand");
      end

      // Second start 20 cycles into a frame is ignored.
      base = done_count;
      pulse_start(8'h11, 8'h5A, 1);
      repeat (19) @(negedge clk);
      pulse_start(8'hFF, 8'h00, 0);
      wait_done(base + 1, 200, "timeout_busy");
      repeat (100) @(negedge clk);
      check("busy_reject_frames", done_count, base + 1);
      check("busy_reject_ce0", ce0, 1);

      // Back-to-back with start held.
      base = done_count;
      @(negedge clk);
      tx_data = 8'h80;
      start = 1'b1;
      acc = cyc + 1;
      exp_q.push_back('{tx: 8'h80, rx: 8'hC7});
      exp_q.push_back('{tx: 8'h01, rx: 8'h2E});
      pq.push_back(8'hC7);
      pq.push_back(8'h2E);
      while (cyc < acc + 10) @(negedge clk);
      tx_data = 8'h01;
      while (cyc < acc + NEXT_ACC) @(negedge clk);
      start = 1'b0;
      wait_done(base + 2, 300, "timeout_b2b");
      check("b2b_ce0_gap", last_gap, GAP);

      // Reset in the middle of a frame.
      base = done_count;
      pulse_start(8'hC3, 8'h96, 1);
      repeat (29) @(negedge clk);
      check("ce0_midframe", ce0, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_ce0", ce0, 1);
      check("abort_sclk", sclk, 0);
      check("abort_busy", busy, 0);
      check("abort_rx", rx_data, 0);
      check("abort_done", done, 0);
      exp_q.delete();
      pq.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("abort_no_done", done_count, base);
      base = done_count;
      pulse_start(8'h6B, 8'hD4, 1);
      wait_done(base + 1, 200, "timeout_after_abort");

      // Minimum divider instance.
      @(negedge clk);
      tx2 = 8'hFF;
      start2 = 1'b1;
      acc = cyc + 1;
      @(negedge clk);
      start2 = 1'b0;
      lowcnt = 0;
      seen = 0;
      dcyc = 0;
      for (int n = 0; n < 80 && !seen; n++) begin
         if (!ce0_2 && !mosi2) lowcnt++;
         if (done2) begin
            seen = 1;
            dcyc = cyc - acc;
         end
         if (!seen) @(negedge clk);
      end
      check("div2_done_seen", seen, 1);
      check("div2_done_cycle", dcyc, (2 * W + 1) * 2);
      check("div2_rx", rx2, 8'h00);
      check("div2_mosi_low_cycles", lowcnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
